mmu_feeder: RTL and testbench
=============================

Name: mmu_feeder

Overview:
- Streaming sequencer on the input side of the 12x7 matrix-multiply unit. Accepts activation/weight/bias beats over a valid/ready handshake and drives the MMU input, weight, bias and flush ports.
- Counts beats per tile and captures the accumulated MMU result once a tile is complete. Presents that result downstream over a valid/ready handshake.

Parameters:
- ROWS, 12, PE rows; must match the MMU.
- COLS, 7, output columns per PE.
- DEPTH, 4, products per dot product.
- DW, 8, activation/weight width.
- AW, 32, bias/accumulator/result width.
- CW, 16, beat-counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  feeder accepts a beat
- in_last  in  1  beat is last of tile
- in_act  in  DW x [ROWS][COLS][DEPTH]  activations
- in_w  in  DW x [ROWS][DEPTH]  weights
- in_bias  in  AW  tile bias; sampled on first beat only
- mmu_in  out  DW x [ROWS][COLS][DEPTH]  to MMU
- mmu_w  out  DW x [ROWS][DEPTH]  to MMU
- mmu_bias  out  AW  to MMU row-0 bias
- mmu_flush  out  1  clears MMU accumulators at next edge
- mmu_out  in  AW x [COLS]  MMU column sums
- res_valid  out  1  result held
- res_ready  in  1  downstream accepts result
- res_data  out  AW x [COLS]  captured tile result
- res_beats  out  CW  beats accumulated into res_data

Behaviour:
- Clock/reset: one clock. Reset is asynchronous and active-low on rst_n. All registers clear to 0 and state goes to CLEAR.
- MMU contract per cycle: the MMU adds ROW0 bias plus the sum over r,k of in[r][c][k]*w[r][k] into accumulator c. mmu_flush=1 zeroes the accumulators at the edge. mmu_out is combinational from the accumulators.
- mmu_in, mmu_w, mmu_bias and mmu_flush are registered outputs.
  - In any cycle without a driven beat, mmu_in, mmu_w and mmu_bias are all 0, so the accumulators hold.
- States:
  - CLEAR: mmu_flush=1 for exactly one cycle; in_ready=0; beat counter cleared. Next state is ACCUM.
  - ACCUM: in_ready=1. On a handshake, the beat is registered onto mmu_in/mmu_w at the next edge.
    - mmu_bias is set to in_bias if this is the first beat of the tile, otherwise 0.
    - The beat counter increments, saturating at 2^CW-1.
    - A handshake with in_last=1 moves the state to DRAIN.
    - in_valid gaps insert zero cycles and do not affect the result.
  - DRAIN: one cycle; in_ready=0; the MMU absorbs the final beat.
  - CAPTURE: mmu_out is now complete. in_ready=0.
    - If res_valid=0, or res_valid&res_ready this cycle: load res_data<=mmu_out and res_beats<=counter, set res_valid=1, go to CLEAR.
    - Otherwise stay in CAPTURE. The MMU holds its sums while stalled.
- Latency: last-beat handshake in cycle A gives res_valid=1 from cycle A+3.
  - The earliest next-tile beat is accepted in cycle A+4 (CLEAR at A+3).
- Result handshake:
  - res_valid&res_ready clears res_valid at the edge unless a CAPTURE load occurs in the same cycle; load wins.
  - res_data and res_beats are stable while res_valid=1 and res_ready=0.
- Single-beat tile (in_last on first beat) is legal: bias and data are applied in the same beat.
- in_last is ignored without in_valid.
- Reset mid-tile discards partial work; the first post-reset cycle is CLEAR.
- Arithmetic is done in the MMU; the feeder never modifies data.

Test Plan:
- One beat with all in_act=1, all in_w=1, in_bias=5, in_last=1, res_ready=1 -> res_data[c]=53 for all c, res_beats=1, res_valid rising 3 cycles after the handshake.
- Three beats of the same data with in_bias=5 on the first beat (in_bias=99 presented on beats 2-3) -> res_data[c]=149, res_beats=3; confirms bias is applied once.
- Same three-beat tile with in_valid low for 2 cycles between beats -> identical 149 result; mmu_in and mmu_w are 0 during the gaps.
- res_ready=0 while a second tile (one beat, bias 0, result 48) completes:
  - first result 53 holds and the FSM stalls in CAPTURE with in_ready=0;
  - res_ready=1 for one cycle -> 48 loaded the same cycle and res_valid stays 1.
- rst_n low for 1 cycle after 2 beats of a tile:
  - all outputs drop to 0 asynchronously;
  - next cycle mmu_flush=1;
  - a new single-beat tile with bias 0 then yields 48, not 149.
- Column-distinct data: in_act[r][c][k]=c, in_w=2, bias=0 -> res_data[c]=96*c.

Source files
------------

// File: rtl/mmu_feeder_if.sv
// mmu_feeder_if: groups the feeder's beat input, MMU drive and result output signals.
// Ports: in_* beat stream (valid/ready), mmu_* MMU drive and column sums, res_* result (valid/ready).
// Modports: master = environment (upstream, MMU, result sink); slave = the feeder.
interface mmu_feeder_if #(
  parameter int ROWS  = 12,
  parameter int COLS  = 7,
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int AW    = 32,
  parameter int CW    = 16
);
  logic                                         in_valid;
  logic                                         in_ready;
  logic                                         in_last;
  logic [ROWS-1:0][COLS-1:0][DEPTH-1:0][DW-1:0] in_act;
  logic [ROWS-1:0][DEPTH-1:0][DW-1:0]           in_w;
  logic [AW-1:0]                                in_bias;

  logic [ROWS-1:0][COLS-1:0][DEPTH-1:0][DW-1:0] mmu_in;
  logic [ROWS-1:0][DEPTH-1:0][DW-1:0]           mmu_w;
  logic [AW-1:0]                                mmu_bias;
  logic                                         mmu_flush;
  logic [COLS-1:0][AW-1:0]                      mmu_out;

  logic                                         res_valid;
  logic                                         res_ready;
  logic [COLS-1:0][AW-1:0]                      res_data;
  logic [CW-1:0]                                res_beats;

  modport master (
    output in_valid, in_last, in_act, in_w, in_bias,
    input  in_ready,
    input  mmu_in, mmu_w, mmu_bias, mmu_flush,
    output mmu_out,
    input  res_valid, res_data, res_beats,
    output res_ready
  );

  modport slave (
    input  in_valid, in_last, in_act, in_w, in_bias,
    output in_ready,
    output mmu_in, mmu_w, mmu_bias, mmu_flush,
    input  mmu_out,
    output res_valid, res_data, res_beats,
    input  res_ready
  );
endinterface

// File: rtl/mmu_feeder.sv
// mmu_feeder: sequences act/weight/bias beats into the 12x7 MMU and captures each tile's column sums.
// Latency: last beat accepted in cycle A -> res_valid from A+3; next tile beat accepted from A+4.
// Backpressure: in_ready low outside ACCUM; an unconsumed result stalls the FSM in CAPTURE.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries in_*, mmu_* and res_* groups.
module mmu_feeder #(
  parameter int ROWS  = 12,
  parameter int COLS  = 7,
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int AW    = 32,
  parameter int CW    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mmu_feeder_if.slave  bus
);

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    ACCUM   = 2'd1,
    DRAIN   = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t                                       state;
  logic                                         in_rdy_q;
  logic                                         flush_q;
  logic [ROWS-1:0][COLS-1:0][DEPTH-1:0][DW-1:0] act_q;
  logic [ROWS-1:0][DEPTH-1:0][DW-1:0]           w_q;
  logic [AW-1:0]                                bias_q;
  logic [CW-1:0]                                beat_cnt;
  logic                                         res_vld_q;
  logic [COLS-1:0][AW-1:0]                      res_dat_q;
  logic [CW-1:0]                                res_beats_q;

  logic in_hs;
  logic res_take;

  assign in_hs    = bus.in_valid & in_rdy_q;
  assign res_take = res_vld_q & bus.res_ready;

  assign bus.in_ready  = in_rdy_q;
  assign bus.mmu_in    = act_q;
  assign bus.mmu_w     = w_q;
  assign bus.mmu_bias  = bias_q;
  assign bus.mmu_flush = flush_q;
  assign bus.res_valid = res_vld_q;
  assign bus.res_data  = res_dat_q;
  assign bus.res_beats = res_beats_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CLEAR;
      in_rdy_q    <= 1'b0;
      flush_q     <= 1'b0;
      act_q       <= '0;
      w_q         <= '0;
      bias_q      <= '0;
      beat_cnt    <= '0;
      res_vld_q   <= 1'b0;
      res_dat_q   <= '0;
      res_beats_q <= '0;
    end else begin
      // MMU drive is zero unless a beat is taken, so idle cycles leave the accumulators alone.
      act_q   <= '0;
      w_q     <= '0;
      bias_q  <= '0;
      flush_q <= 1'b0;

      if (res_take) res_vld_q <= 1'b0;

      case (state)
        CLEAR: begin
          beat_cnt <= '0;
          // Entered from CAPTURE the flush is already on the port this cycle. Straight out of
          // reset it is not, so spend this cycle raising it and leave CLEAR on the next one.
          if (flush_q) begin
            in_rdy_q <= 1'b1;
            state    <= ACCUM;
          end else begin
            flush_q <= 1'b1;
          end
        end

        ACCUM: begin
          if (in_hs) begin
            act_q  <= bus.in_act;
            w_q    <= bus.in_w;
            bias_q <= (beat_cnt == '0) ? bus.in_bias : '0;
            if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
            if (bus.in_last) begin
              in_rdy_q <= 1'b0;
              state    <= DRAIN;
            end
          end
        end

        // Final beat sits on the MMU port this cycle and lands in the accumulators at the edge.
        DRAIN: state <= CAPTURE;

        CAPTURE: begin
          // A consume in the same cycle frees the holding register, and the new load wins.
          if (!res_vld_q || bus.res_ready) begin
            res_dat_q   <= bus.mmu_out;
            res_beats_q <= beat_cnt;
            res_vld_q   <= 1'b1;
            flush_q     <= 1'b1;
            state       <= CLEAR;
          end
        end

        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_feeder.sv
module tb_mmu_feeder;
  localparam int ROWS  = 12;
  localparam int COLS  = 7;
  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int AW    = 32;
  localparam int CW    = 16;

  typedef logic [ROWS-1:0][COLS-1:0][DEPTH-1:0][DW-1:0] act_t;
  typedef logic [ROWS-1:0][DEPTH-1:0][DW-1:0]           w_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mmu_feeder_if #(.ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH), .DW(DW), .AW(AW), .CW(CW)) bus ();

  mmu_feeder #(.ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH), .DW(DW), .AW(AW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Column dot product of one beat: sum over r,k of in[r][c][k]*w[r][k].
  function automatic logic [AW-1:0] col_dot(input act_t a, input w_t w, input int c);
    logic [AW-1:0] s;
    s = '0;
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < DEPTH; k++)
        s += AW'(a[r][c][k]) * AW'(w[r][k]);
    return s;
  endfunction

  // Behavioural MMU: accumulates bias plus column products every cycle, flush zeroes.
  logic [COLS-1:0][AW-1:0] acc = '0;
  assign bus.mmu_out = acc;
  always @(posedge clk) begin
    if (bus.mmu_flush) acc <= '0;
    else for (int c = 0; c < COLS; c++)
      acc[c] <= acc[c] + bus.mmu_bias + col_dot(bus.mmu_in, bus.mmu_w, c);
  end

  function automatic act_t act_fill(input int v);
    act_t a;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) for (int k = 0; k < DEPTH; k++)
      a[r][c][k] = DW'(v);
    return a;
  endfunction

  function automatic act_t act_by_col();
    act_t a;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) for (int k = 0; k < DEPTH; k++)
      a[r][c][k] = DW'(c);
    return a;
  endfunction

  function automatic act_t act_rand();
    act_t a;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) for (int k = 0; k < DEPTH; k++)
      a[r][c][k] = DW'($urandom_range(0, 255));
    return a;
  endfunction

  function automatic w_t w_fill(input int v);
    w_t w;
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < DEPTH; k++) w[r][k] = DW'(v);
    return w;
  endfunction

  function automatic w_t w_rand();
    w_t w;
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < DEPTH; k++) w[r][k] = DW'($urandom_range(0, 255));
    return w;
  endfunction

  // Called at a negedge; returns at the negedge following the handshake edge. Data is left on the bus.
  task automatic send_beat(input act_t a, input w_t w, input logic [AW-1:0] b, input logic last);
    int guard;
    guard = 0;
    bus.in_act = a; bus.in_w = w; bus.in_bias = b; bus.in_last = last; bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) begin
      vectors++; miscompares++;
      $display("FAIL send_beat: in_ready got %b, required 1 within 100 cycles", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset in_ready got %b exp 0", bus.in_ready); end
    vectors++; if (bus.mmu_flush !== 1'b0) begin miscompares++; $display("FAIL reset mmu_flush got %b exp 0", bus.mmu_flush); end
    vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL reset res_valid got %b exp 0", bus.res_valid); end
    vectors++; if (bus.res_beats !== '0) begin miscompares++; $display("FAIL reset res_beats got %0d exp 0", bus.res_beats); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (bus.mmu_flush !== 1'b1) begin miscompares++; $display("FAIL reset_flush got %b exp 1", bus.mmu_flush); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_clear in_ready got %b exp 0", bus.in_ready); end
    @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_accum in_ready got %b exp 1", bus.in_ready); end
    vectors++; if (bus.mmu_flush !== 1'b0) begin miscompares++; $display("FAIL reset_accum mmu_flush got %b exp 0", bus.mmu_flush); end
  endtask

  task automatic test_single_beat();
    bus.res_ready = 1'b1;
    send_beat(act_fill(1), w_fill(1), 32'd5, 1'b1);
    // cycle A+1: beat on the MMU port
    vectors++; if (bus.mmu_in !== act_fill(1)) begin miscompares++; $display("FAIL single mmu_in elem0 got %0d exp 1", bus.mmu_in[0][0][0]); end
    vectors++; if (bus.mmu_bias !== 32'd5) begin miscompares++; $display("FAIL single mmu_bias got %0d exp 5", bus.mmu_bias); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL single drain in_ready got %b exp 0", bus.in_ready); end
    @(negedge clk); // A+2
    vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL single early res_valid got %b exp 0", bus.res_valid); end
    vectors++; if (bus.mmu_in !== '0) begin miscompares++; $display("FAIL single idle mmu_in elem0 got %0d exp 0", bus.mmu_in[0][0][0]); end
    @(negedge clk); // A+3
    vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL single res_valid got %b exp 1", bus.res_valid); end
    vectors++; if (bus.res_beats !== 16'd1) begin miscompares++; $display("FAIL single res_beats got %0d exp 1", bus.res_beats); end
    vectors++; if (bus.mmu_flush !== 1'b1) begin miscompares++; $display("FAIL single clear flush got %b exp 1", bus.mmu_flush); end
    for (int c = 0; c < COLS; c++) begin
      vectors++; if (bus.res_data[c] !== 32'd53) begin miscompares++; $display("FAIL single res_data[%0d] got %0d exp 53", c, bus.res_data[c]); end
    end
    @(negedge clk); // A+4
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL single next in_ready got %b exp 1", bus.in_ready); end
    vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL single consumed res_valid got %b exp 0", bus.res_valid); end
  endtask

  task automatic test_multi_beat();
    bus.res_ready = 1'b1;
    send_beat(act_fill(1), w_fill(1), 32'd5, 1'b0);
    send_beat(act_fill(1), w_fill(1), 32'd99, 1'b0);
    vectors++; if (bus.mmu_bias !== '0) begin miscompares++; $display("FAIL multi beat2 mmu_bias got %0d exp 0", bus.mmu_bias); end
    send_beat(act_fill(1), w_fill(1), 32'd99, 1'b1);
    repeat (2) @(negedge clk);
    vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL multi res_valid got %b exp 1", bus.res_valid); end
    vectors++; if (bus.res_beats !== 16'd3) begin miscompares++; $display("FAIL multi res_beats got %0d exp 3", bus.res_beats); end
    for (int c = 0; c < COLS; c++) begin
      vectors++; if (bus.res_data[c] !== 32'd149) begin miscompares++; $display("FAIL multi res_data[%0d] got %0d exp 149", c, bus.res_data[c]); end
    end
    @(negedge clk);
  endtask

  task automatic test_gaps();
    bus.res_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      send_beat(act_fill(1), w_fill(1), (b == 0) ? 32'd5 : 32'd99, (b == 2) ? 1'b1 : 1'b0);
      if (b < 2) begin
        bus.in_last = 1'b1; // no valid, so it must not end the tile
        repeat (2) begin
          @(negedge clk);
          vectors++; if (bus.mmu_in !== '0) begin miscompares++; $display("FAIL gap mmu_in elem0 got %0d exp 0", bus.mmu_in[0][0][0]); end
          vectors++; if (bus.mmu_w !== '0) begin miscompares++; $display("FAIL gap mmu_w elem0 got %0d exp 0", bus.mmu_w[0][0]); end
          vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL gap in_ready got %b exp 1", bus.in_ready); end
        end
      end
    end
    repeat (2) @(negedge clk);
    vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL gaps res_valid got %b exp 1", bus.res_valid); end
    vectors++; if (bus.res_beats !== 16'd3) begin miscompares++; $display("FAIL gaps res_beats got %0d exp 3", bus.res_beats); end
    for (int c = 0; c < COLS; c++) begin
      vectors++; if (bus.res_data[c] !== 32'd149) begin miscompares++; $display("FAIL gaps res_data[%0d] got %0d exp 149", c, bus.res_data[c]); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bus.res_ready = 1'b0;
    send_beat(act_fill(1), w_fill(1), 32'd5, 1'b1);
    repeat (3) @(negedge clk); // next tile can start here
    send_beat(act_fill(1), w_fill(1), 32'd0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL stall res_valid got %b exp 1", bus.res_valid); end
      vectors++; if (bus.res_data[3] !== 32'd53) begin miscompares++; $display("FAIL stall res_data[3] got %0d exp 53", bus.res_data[3]); end
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall in_ready got %b exp 0", bus.in_ready); end
      vectors++; if (bus.mmu_flush !== 1'b0) begin miscompares++; $display("FAIL stall mmu_flush got %b exp 0", bus.mmu_flush); end
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL reload res_valid got %b exp 1", bus.res_valid); end
    vectors++; if (bus.res_beats !== 16'd1) begin miscompares++; $display("FAIL reload res_beats got %0d exp 1", bus.res_beats); end
    vectors++; if (bus.mmu_flush !== 1'b1) begin miscompares++; $display("FAIL reload mmu_flush got %b exp 1", bus.mmu_flush); end
    for (int c = 0; c < COLS; c++) begin
      vectors++; if (bus.res_data[c] !== 32'd48) begin miscompares++; $display("FAIL reload res_data[%0d] got %0d exp 48", c, bus.res_data[c]); end
    end
    @(negedge clk);
    vectors++; if (bus.res_data[0] !== 32'd48) begin miscompares++; $display("FAIL hold res_data[0] got %0d exp 48", bus.res_data[0]); end
    bus.res_ready = 1'b1;
    @(negedge clk);
    vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL drain res_valid got %b exp 0", bus.res_valid); end
  endtask

  task automatic test_reset_mid_tile();
    bus.res_ready = 1'b1;
    send_beat(act_fill(1), w_fill(1), 32'd5, 1'b0);
    send_beat(act_fill(1), w_fill(1), 32'd5, 1'b0);
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.mmu_in !== '0) begin miscompares++; $display("FAIL arst mmu_in elem0 got %0d exp 0", bus.mmu_in[0][0][0]); end
    vectors++; if (bus.mmu_w !== '0) begin miscompares++; $display("FAIL arst mmu_w elem0 got %0d exp 0", bus.mmu_w[0][0]); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL arst in_ready got %b exp 0", bus.in_ready); end
    vectors++; if (bus.mmu_bias !== '0) begin miscompares++; $display("FAIL arst mmu_bias got %0d exp 0", bus.mmu_bias); end
    vectors++; if (bus.res_data !== '0) begin miscompares++; $display("FAIL arst res_data[0] got %0d exp 0", bus.res_data[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (bus.mmu_flush !== 1'b1) begin miscompares++; $display("FAIL arst flush got %b exp 1", bus.mmu_flush); end
    @(negedge clk);
    send_beat(act_fill(1), w_fill(1), 32'd0, 1'b1);
    repeat (2) @(negedge clk);
    vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL arst res_valid got %b exp 1", bus.res_valid); end
    vectors++; if (bus.res_beats !== 16'd1) begin miscompares++; $display("FAIL arst res_beats got %0d exp 1", bus.res_beats); end
    for (int c = 0; c < COLS; c++) begin
      vectors++; if (bus.res_data[c] !== 32'd48) begin miscompares++; $display("FAIL arst res_data[%0d] got %0d exp 48", c, bus.res_data[c]); end
    end
    @(negedge clk);
  endtask

  task automatic test_column_distinct();
    bus.res_ready = 1'b1;
    send_beat(act_by_col(), w_fill(2), 32'd0, 1'b1);
    repeat (2) @(negedge clk);
    for (int c = 0; c < COLS; c++) begin
      vectors++; if (bus.res_data[c] !== AW'(96 * c)) begin miscompares++; $display("FAIL coldist res_data[%0d] got %0d exp %0d", c, bus.res_data[c], 96 * c); end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      int            n;
      int            guard;
      bit            taken;
      act_t          a;
      w_t            w;
      logic [AW-1:0] b;
      logic [AW-1:0] exp_sum [COLS];
      n = $urandom_range(1, 4);
      for (int c = 0; c < COLS; c++) exp_sum[c] = '0;
      for (int i = 0; i < n; i++) begin
        a = act_rand(); w = w_rand(); b = $urandom;
        for (int c = 0; c < COLS; c++) exp_sum[c] += col_dot(a, w, c) + ((i == 0) ? b : '0);
        send_beat(a, w, b, (i == n - 1) ? 1'b1 : 1'b0);
        repeat ($urandom_range(0, 2)) begin bus.in_last = 1'($urandom_range(0, 1)); @(negedge clk); end
      end
      guard = 0; taken = 0;
      while (!taken && guard < 200) begin
        bus.res_ready = 1'($urandom_range(0, 1));
        if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
          vectors++; if (bus.res_beats !== CW'(n)) begin miscompares++; $display("FAIL rand tile %0d res_beats got %0d exp %0d", t, bus.res_beats, n); end
          for (int c = 0; c < COLS; c++) begin
            vectors++; if (bus.res_data[c] !== exp_sum[c]) begin miscompares++; $display("FAIL rand tile %0d res_data[%0d] got %0d exp %0d", t, c, bus.res_data[c], exp_sum[c]); end
          end
          taken = 1;
        end
        @(negedge clk);
        guard++;
      end
      if (!taken) begin vectors++; miscompares++; $display("FAIL rand tile %0d res_valid got 0 exp 1 within 200 cycles", t); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_act = '0; bus.in_w = '0;
    bus.in_bias = '0; bus.res_ready = 1'b0;
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_gaps();
    test_backpressure();
    test_reset_mid_tile();
    test_column_distinct();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", vectors);
    $fatal(1);
  end
endmodule
